// File: rtl/video_pkg.sv
// Shared definitions for the PET video path: capture FSM states and frame geometry
// common to the video generator and the capture block.
package video_pkg;

    typedef enum logic [2:0] {
        WAIT_VSYNC,
        V_BLANK,
        WAIT_HSYNC,
        H_BLANK,
        ACTIVE
    } capture_state_t;

    localparam int PET_H_BYTES = 40;
    localparam int PET_V_LINES = 200;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-flop history
// stage used to flag the first synchronized high cycle (rising edge).
module sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/video_capture.sv
// Rebuilds the visible monochrome frame from h_sync/v_sync/video into packed bytes
// for a capture buffer, and measures lines per frame to report lock.
module video_capture
    import video_pkg::*;
#(
    parameter int H_OFFSET = 16,
    parameter int H_BYTES  = PET_H_BYTES,
    parameter int V_OFFSET = 20,
    parameter int V_LINES  = PET_V_LINES,
    parameter int ADDR_W   = 13
) (
    input  logic              clk16_i,
    input  logic              reset_i,
    input  logic              pixel_en_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    input  logic              video_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic              locked_o,
    output logic [9:0]        line_count_o
);

    localparam logic [9:0]        H_OFF_LAST = 10'(H_OFFSET - 1);
    localparam logic [9:0]        V_OFF_LAST = 10'(V_OFFSET - 1);
    localparam logic [9:0]        V_LAST     = 10'(V_LINES - 1);
    localparam logic [7:0]        COL_LAST   = 8'(H_BYTES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_BYTES);
    localparam logic [9:0]        CNT_MAX    = 10'd1023;

    logic h_rise, v_rise;

    sync_edge u_h_sync (.clk_i(clk16_i), .reset_i(reset_i), .async_i(h_sync_i), .rise_o(h_rise));
    sync_edge u_v_sync (.clk_i(clk16_i), .reset_i(reset_i), .async_i(v_sync_i), .rise_o(v_rise));

    capture_state_t    state_q, state_d;
    logic [1:0]        pen_sync_q, pen_sync_d, vid_sync_q, vid_sync_d;
    logic [9:0]        vcnt_q, vcnt_d, hcnt_q, hcnt_d;
    logic [7:0]        col_q, col_d, shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [9:0]        line_q, line_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [9:0]        line_ctr_q, line_ctr_d, line_count_q, line_count_d;
    logic [9:0]        prev_count_q, prev_count_d;
    logic              armed_q, armed_d, has_prev_q, has_prev_d, locked_q, locked_d;
    logic              overrun_q, overrun_d, frame_pend_q, frame_pend_d;
    logic              frame_done_q, frame_done_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    // pixel_en/video go through the same two-flop depth as the syncs so ordering holds
    logic pen, vid;
    assign pen = pen_sync_q[1];
    assign vid = vid_sync_q[1];

    always_comb begin
        state_d      = state_q;
        pen_sync_d   = {pen_sync_q[0], pixel_en_i};
        vid_sync_d   = {vid_sync_q[0], video_i};
        vcnt_d       = vcnt_q;
        hcnt_d       = hcnt_q;
        col_d        = col_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        line_d       = line_q;
        line_base_d  = line_base_q;
        line_ctr_d   = line_ctr_q;
        line_count_d = line_count_q;
        prev_count_d = prev_count_q;
        armed_d      = armed_q;
        has_prev_d   = has_prev_q;
        locked_d     = locked_q;
        overrun_d    = overrun_q;
        frame_pend_d = 1'b0;
        frame_done_d = frame_pend_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (h_rise && line_ctr_q != CNT_MAX) begin
            line_ctr_d = line_ctr_q + 10'd1;
        end

        if (v_rise) begin
            // The first v_sync only arms; the second stores a reference count
            line_count_d = line_ctr_q;
            line_ctr_d   = '0;
            line_base_d  = '0;
            line_d       = '0;
            overrun_d    = 1'b0;
            vcnt_d       = '0;
            state_d      = V_BLANK;
            armed_d      = 1'b1;
            if (armed_q) begin
                if (has_prev_q) begin
                    locked_d = (line_ctr_q == prev_count_q) && (line_ctr_q != '0);
                end
                prev_count_d = line_ctr_q;
                has_prev_d   = 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_VSYNC: state_d = WAIT_VSYNC;
                V_BLANK: begin
                    if (h_rise) begin
                        if (vcnt_q == V_OFF_LAST) state_d = WAIT_HSYNC;
                        else                      vcnt_d  = vcnt_q + 10'd1;
                    end
                end
                WAIT_HSYNC: begin
                    if (h_rise) begin
                        state_d = H_BLANK;
                        hcnt_d  = '0;
                    end
                end
                H_BLANK: begin
                    if (h_rise) begin
                        hcnt_d    = '0;
                        overrun_d = 1'b1;
                    end else if (pen) begin
                        if (hcnt_q == H_OFF_LAST) begin
                            state_d = ACTIVE;
                            col_d   = '0;
                            bit_d   = '0;
                        end else begin
                            hcnt_d = hcnt_q + 10'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (h_rise) begin
                        // Truncated line: drop the partial byte, this edge opens the next line
                        overrun_d   = 1'b1;
                        line_base_d = line_base_q + LINE_STEP;
                        hcnt_d      = '0;
                        if (line_q == V_LAST) begin
                            state_d = WAIT_VSYNC;
                        end else begin
                            line_d  = line_q + 10'd1;
                            state_d = H_BLANK;
                        end
                    end else if (pen) begin
                        shift_d = {shift_q[6:0], vid};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {shift_q[6:0], vid};
                            wr_addr_d = line_base_q + ADDR_W'(col_q);
                            col_d     = col_q + 8'd1;
                            if (col_q == COL_LAST) begin
                                line_base_d = line_base_q + LINE_STEP;
                                if (line_q == V_LAST) begin
                                    frame_pend_d = 1'b1;
                                    state_d      = WAIT_VSYNC;
                                end else begin
                                    line_d  = line_q + 10'd1;
                                    state_d = WAIT_HSYNC;
                                end
                            end
                        end
                    end
                end
                default: state_d = WAIT_VSYNC;
            endcase
        end
    end

    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= WAIT_VSYNC;
            pen_sync_q   <= '0;
            vid_sync_q   <= '0;
            vcnt_q       <= '0;
            hcnt_q       <= '0;
            col_q        <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            line_q       <= '0;
            line_base_q  <= '0;
            line_ctr_q   <= '0;
            line_count_q <= '0;
            prev_count_q <= '0;
            armed_q      <= 1'b0;
            has_prev_q   <= 1'b0;
            locked_q     <= 1'b0;
            overrun_q    <= 1'b0;
            frame_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            pen_sync_q   <= pen_sync_d;
            vid_sync_q   <= vid_sync_d;
            vcnt_q       <= vcnt_d;
            hcnt_q       <= hcnt_d;
            col_q        <= col_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            line_q       <= line_d;
            line_base_q  <= line_base_d;
            line_ctr_q   <= line_ctr_d;
            line_count_q <= line_count_d;
            prev_count_q <= prev_count_d;
            armed_q      <= armed_d;
            has_prev_q   <= has_prev_d;
            locked_q     <= locked_d;
            overrun_q    <= overrun_d;
            frame_pend_q <= frame_pend_d;
            frame_done_q <= frame_done_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;
    assign locked_o     = locked_q;
    assign line_count_o = line_count_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a shrunken frame geometry, with a pixel-level
// frame model producing the expected byte stream and status flags.
module tb_video_capture;

    localparam int H_OFFSET = 4;
    localparam int H_BYTES  = 4;
    localparam int V_OFFSET = 3;
    localparam int V_LINES  = 8;
    localparam int ADDR_W   = 13;
    localparam int W        = ADDR_W + 8;
    localparam int FULL_PIX = H_OFFSET + 8 * H_BYTES + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic pen, hs, vs, vid;
    logic              wr_en, frame_done, overrun, locked;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [9:0]        line_count;

    always #5 clk = ~clk;

    video_capture #(
        .H_OFFSET(H_OFFSET), .H_BYTES(H_BYTES), .V_OFFSET(V_OFFSET),
        .V_LINES(V_LINES), .ADDR_W(ADDR_W)
    ) dut (
        .clk16_i(clk), .reset_i(rst), .pixel_en_i(pen), .h_sync_i(hs),
        .v_sync_i(vs), .video_i(vid), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .frame_done_o(frame_done), .overrun_o(overrun),
        .locked_o(locked), .line_count_o(line_count)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int wr_log[$];
    int wr_total   = 0;
    int got_frames = 0;

    // frame model state
    bit         m_seen, m_overrun, m_locked;
    int         m_k, m_cnt, m_p, m_nvs, m_prev, m_line_count, exp_frames;
    logic [7:0] m_byte;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_overrun = 0; m_locked = 0;
        m_k = 0; m_cnt = 0; m_p = 0; m_nvs = 0; m_prev = 0; m_line_count = 0;
        m_byte = '0;
        exp_q.delete();
    endtask

    // ---------------- scoreboard / compare ----------------
    logic [W-1:0] cmp_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_total++;
                wr_log.push_back(int'(wr_addr));
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), int'(cmp_e[W-1:8]));
                    check("wr_data", int'(wr_data), int'(cmp_e[7:0]));
                end
            end
            if (frame_done) got_frames++;
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_vsync();
        m_line_count = m_cnt;
        m_nvs++;
        if (m_nvs >= 3) m_locked = (m_cnt == m_prev) && (m_cnt != 0);
        if (m_nvs >= 2) m_prev = m_cnt;
        m_cnt = 0; m_k = 0; m_p = 0; m_seen = 1; m_overrun = 0;
        vs = 1'b1; cyc(); cyc();
        vs = 1'b0; cyc(); cyc();
    endtask

    task automatic do_hsync();
        int l;
        l = m_k - V_OFFSET - 1;
        // the line now ending was visible and never reached its last byte
        if (m_seen && m_k > V_OFFSET && l < V_LINES && m_p < H_OFFSET + 8 * H_BYTES)
            m_overrun = 1;
        m_k++;
        if (m_cnt < 1023) m_cnt++;
        m_p = 0;
        hs = 1'b1; cyc(); cyc();
        hs = 1'b0; cyc();
    endtask

    task automatic pixel(input logic b);
        int l, v;
        l = m_k - V_OFFSET - 1;
        v = m_p - H_OFFSET;
        if (m_seen && m_k > V_OFFSET && l < V_LINES && v >= 0 && v < 8 * H_BYTES) begin
            m_byte = {m_byte[6:0], b};
            if (v % 8 == 7) begin
                exp_q.push_back({ADDR_W'(l * H_BYTES + v / 8), m_byte});
                if (l == V_LINES - 1 && v == 8 * H_BYTES - 1) exp_frames++;
            end
        end
        m_p++;
        pen = 1'b1; vid = b; cyc();
        pen = 1'b0; vid = 1'b0; cyc();
    endtask

    // mode 0: pixels 0 and 7 of every visible byte set; mode 1: random pixels
    task automatic send_line(input int npix, input int mode);
        logic b;
        int v;
        do_hsync();
        for (int i = 0; i < npix; i++) begin
            v = i - H_OFFSET;
            if (mode == 0) b = (i >= H_OFFSET) && ((v % 8 == 0) || (v % 8 == 7));
            else           b = 1'($urandom_range(0, 1));
            pixel(b);
        end
    endtask

    task automatic send_frame(input int mode, input int trunc_line, input int trunc_vis, input int extra);
        do_vsync();
        repeat (V_OFFSET) do_hsync();
        for (int l = 0; l < V_LINES; l++) begin
            if (l == trunc_line) send_line(H_OFFSET + trunc_vis, mode);
            else                 send_line(FULL_PIX, mode);
        end
        repeat (extra) do_hsync();
    endtask

    task automatic blank_frame(input int n);
        do_vsync();
        repeat (n) do_hsync();
    endtask

    task automatic check_status(input string tag);
        repeat (4) cyc();
        check({tag, "_line_count"}, int'(line_count), m_line_count);
        check({tag, "_locked"}, int'(locked), int'(m_locked));
        check({tag, "_overrun"}, int'(overrun), int'(m_overrun));
        check({tag, "_frames"}, got_frames, exp_frames);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_line_count"}, int'(line_count), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int base;
    initial begin
        model_reset();
        exp_frames = 0;
        rst = 1'b1; pen = 1'b0; hs = 1'b0; vs = 1'b0; vid = 1'b0;
        repeat (3) cyc();
        check_outputs_zero("reset");
        rst = 1'b0;
        cyc();

        // Frame A: 0x81 pattern over the whole frame
        base = wr_total;
        send_frame(0, -1, 0, 2);
        check_status("frame_a");
        check("frame_a_writes", wr_total - base, 32);
        check("frame_a_last_addr", wr_log[wr_log.size() - 1], 31);
        check("frame_a_done", got_frames, 1);

        // Frame B: random data, line 2 cut after 13 visible pixels
        base = wr_total;
        send_frame(1, 2, 13, 2);
        check_status("frame_b");
        check("frame_b_writes", wr_total - base, 29);
        check("frame_b_trunc_byte_addr", wr_log[base + 8], 8);
        check("frame_b_next_line_addr", wr_log[base + 9], 12);
        check("frame_b_overrun", int'(overrun), 1);
        check("frame_b_line_count", int'(line_count), 13);

        // Frame C: abandoned during line 5
        do_vsync();
        repeat (V_OFFSET) do_hsync();
        for (int l = 0; l < 5; l++) send_line(FULL_PIX, 0);
        send_line(H_OFFSET + 6, 0);
        check_status("frame_c");
        check("frame_c_locked", int'(locked), 1);
        base = wr_total;

        // Frame E starts with the vsync that abandons C
        send_frame(1, -1, 0, 0);
        check_status("frame_e");
        check("frame_e_line_count", int'(line_count), 9);
        check("frame_e_locked", int'(locked), 0);
        check("frame_e_no_extra_done", got_frames, 3);
        check("frame_e_first_addr", wr_log[base], 0);
        check("frame_e_writes", wr_total - base, 32);

        // Lock sequence: 26, 26, 27 lines
        blank_frame(26);
        blank_frame(26);
        check_status("lock_1");
        check("lock_1_locked", int'(locked), 0);
        blank_frame(27);
        check_status("lock_2");
        check("lock_2_locked", int'(locked), 1);
        do_vsync();
        check_status("lock_3");
        check("lock_3_locked", int'(locked), 0);
        check("lock_3_line_count", int'(line_count), 27);

        // Saturating line counter
        repeat (1030) do_hsync();
        do_vsync();
        check_status("sat");
        check("sat_line_count", int'(line_count), 1023);

        // Reset in the middle of an active line
        repeat (V_OFFSET) do_hsync();
        base = wr_total;
        send_line(H_OFFSET + 20, 1);
        check_status("pre_reset");
        check("pre_reset_writes", wr_total - base, 2);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        base = wr_total;
        send_line(FULL_PIX, 0);
        check_status("post_reset");
        check("post_reset_no_writes", wr_total - base, 0);
        send_frame(0, -1, 0, 1);
        check_status("recovered");
        check("recovered_writes", wr_total - base, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
